// File: rtl/input_channel_ctrl.sv
// -----------------------------------------------------------------------------
// input_channel_ctrl
//
// Controls one router input channel. When an upstream packet arrives, it asks
// the arbiter for a connection to the packet's destination output port. The
// request is retried after a back-off when it is denied. Once connected, the
// controller forwards flits to the crossbar through a one-cycle register. The
// packet is dropped with a one-cycle nack if too many requests are denied, or
// if the arbiter revokes an established connection.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   in_stb_i         upstream packet strobe, held high for the whole packet
//   in_data_i        upstream flit; header bits [1:0] select the output port
//   in_ack_o         flit accepted (CONN only)
//   in_nack_o        one-cycle pulse: packet dropped
//   ctrl_stb_o       transfer strobe to the arbiter
//   ctrl_src_o       one-hot request source (bit PORT_ID, REQ only)
//   ctrl_dest_o      one-hot requested output port (REQ and CONN)
//   arbiter_grant_i  grant vector, bit PORT_ID used
//   arbiter_deny_i   deny vector, bit PORT_ID used
//   out_stb_o        registered flit valid toward the crossbar
//   out_data_o       registered flit toward the crossbar
//   state_o          FSM state encoding, for debug
// -----------------------------------------------------------------------------
module input_channel_ctrl #(
  parameter int PORTS       = 4,
  parameter int DATAW       = 16,
  parameter int PORT_ID     = 0,
  parameter int BACKOFF_CYC = 3,
  parameter int MAX_RETRY   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_stb_i,
  input  logic [DATAW-1:0] in_data_i,
  output logic             in_ack_o,
  output logic             in_nack_o,
  output logic             ctrl_stb_o,
  output logic [PORTS-1:0] ctrl_src_o,
  output logic [PORTS-1:0] ctrl_dest_o,
  input  logic [PORTS-1:0] arbiter_grant_i,
  input  logic [PORTS-1:0] arbiter_deny_i,
  output logic             out_stb_o,
  output logic [DATAW-1:0] out_data_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_CONN    = 3'd2,
    S_BACKOFF = 3'd3,
    S_FAIL    = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

  localparam logic [RW-1:0]    RETRY_LAST = RW'(MAX_RETRY);
  // Back-off counter runs 0..BACKOFF_CYC-1, so BACKOFF lasts BACKOFF_CYC cycles.
  localparam logic [BW-1:0]    BO_LAST    = BW'((BACKOFF_CYC > 0) ? BACKOFF_CYC - 1 : 0);
  localparam logic [PORTS-1:0] SRC_ONEHOT = PORTS'(1) << PORT_ID;

  state_t             state_q, state_d;
  logic [PORTS-1:0]   dest_q, dest_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [BW-1:0]      bo_q, bo_d;
  logic               out_stb_q, out_stb_d;
  logic [DATAW-1:0]   out_data_q, out_data_d;

  logic grant, deny;
  assign grant = arbiter_grant_i[PORT_ID];
  assign deny  = arbiter_deny_i[PORT_ID];

  // Only bit PORT_ID of the arbiter vectors matters to this channel.
  logic unused_arb_bits;
  assign unused_arb_bits = ^{arbiter_grant_i, arbiter_deny_i};

  // NOTE: every register has an async reset here because the controller must
  // drop to IDLE with quiet outputs the moment reset rises, even mid-packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      retry_q    <= '0;
      bo_q       <= '0;
      out_stb_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      dest_q     <= dest_d;
      retry_q    <= retry_d;
      bo_q       <= bo_d;
      out_stb_q  <= out_stb_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case statement can infer a latch.
    state_d     = state_q;
    dest_d      = dest_q;
    retry_d     = retry_q;
    bo_d        = bo_q;
    out_stb_d   = 1'b0;
    out_data_d  = out_data_q;
    in_ack_o    = 1'b0;
    in_nack_o   = 1'b0;
    ctrl_stb_o  = 1'b0;
    ctrl_src_o  = '0;
    ctrl_dest_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (in_stb_i) begin
          state_d = S_REQ;
          dest_d  = PORTS'(1) << in_data_i[1:0];
          retry_d = '0;
        end
      end

      S_REQ: begin
        // A single-cycle source pulse, so the arbiter sees every attempt as
        // a new source change.
        ctrl_stb_o  = 1'b1;
        ctrl_src_o  = SRC_ONEHOT;
        ctrl_dest_o = dest_q;
        if (grant) begin
          state_d = S_CONN;
        end else if (retry_q == RETRY_LAST) begin
          // Saturate rather than wrap: the last tolerated attempt failed.
          state_d = S_FAIL;
        end else begin
          // No answer at all is treated the same as a deny.
          retry_d = retry_q + RW'(1);
          bo_d    = '0;
          state_d = S_BACKOFF;
        end
      end

      S_BACKOFF: begin
        if (!in_stb_i) begin
          state_d = S_IDLE;
        end else if (bo_q == BO_LAST) begin
          state_d = S_REQ;
        end else begin
          bo_d = bo_q + BW'(1);
        end
      end

      S_CONN: begin
        // Strobe follows in_stb_i so the connection is released in the same
        // cycle as the packet ends.
        ctrl_stb_o  = in_stb_i;
        ctrl_dest_o = dest_q;
        in_ack_o    = in_stb_i;
        out_data_d  = in_data_i;
        out_stb_d   = in_stb_i & ~deny;
        if (!in_stb_i) begin
          state_d = S_IDLE;
        end else if (deny) begin
          state_d = S_FAIL;
        end
      end

      S_FAIL: begin
        in_nack_o = 1'b1;
        state_d   = S_DRAIN;
      end

      S_DRAIN: begin
        if (!in_stb_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_stb_o  = out_stb_q;
  assign out_data_o = out_data_q;
  assign state_o    = state_q;

endmodule

// File: doc/input_channel_ctrl.md
INPUT_CHANNEL_CTRL -- requirements
Module: input_channel_ctrl

Interface
REQ-001 Parameters SHALL be: PORTS, default 4, number of router ports; DATAW, default 16, flit width; PORT_ID, default 0, index of this input channel; BACKOFF_CYC, default 3, idle cycles after a deny; MAX_RETRY, default 7, denies tolerated before failure.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_stb_i  input  1  upstream packet strobe, held high for the whole packet.
REQ-006 Port: in_data_i  input  DATAW  upstream flit; first flit is the header; bits [1:0] are the destination output port index.
REQ-007 Port: in_ack_o  output  1  flit accepted.
REQ-008 Port: in_nack_o  output  1  one-cycle pulse, packet dropped.
REQ-009 Port: ctrl_stb_o  output  1  forward-transfer strobe to the arbiter stb bit PORT_ID.
REQ-010 Port: ctrl_src_o  output  PORTS  one-hot request source, bit PORT_ID only.
REQ-011 Port: ctrl_dest_o  output  PORTS  one-hot requested output port.
REQ-012 Port: arbiter_grant_i  input  PORTS  arbiter grant vector; only bit PORT_ID is used.
REQ-013 Port: arbiter_deny_i  input  PORTS  arbiter deny vector; only bit PORT_ID is used.
REQ-014 Port: out_stb_o  output  1  flit valid toward the crossbar.
REQ-015 Port: out_data_o  output  DATAW  registered flit toward the crossbar.
REQ-016 Port: state_o  output  3  current FSM state encoding, for debug.

Function
REQ-017 FSM states SHALL be IDLE=0, REQ=1, CONN=2, BACKOFF=3, FAIL=4, DRAIN=5.
- IDLE: on in_stb_i=1 -> REQ, latching dest=onehot(in_data_i[1:0]) and clearing retry count.
REQ-018 In REQ, ctrl_src_o[PORT_ID]=1 and ctrl_stb_o=1 SHALL hold for exactly one cycle; grant/deny are sampled combinationally in that same cycle.
- grant bit -> CONN.
- deny bit, or neither bit -> BACKOFF; retry+1.
- retry==MAX_RETRY at the deny -> FAIL.
REQ-019 ctrl_src_o SHALL be zero in every state except REQ, so that each request is seen by the arbiter as a source change.
REQ-020 ctrl_dest_o SHALL equal the latched dest in REQ and CONN, and zero otherwise.
REQ-021 In BACKOFF, ctrl_stb_o=0 and a counter SHALL run BACKOFF_CYC cycles, then -> REQ; in_stb_i=0 during BACKOFF -> IDLE.
REQ-022 CONN behaviour:
- ctrl_stb_o=1 and in_ack_o=in_stb_i.
- out_data_o<=in_data_i and out_stb_o<=in_stb_i, one-cycle latency; the header flit is forwarded in the first CONN cycle.
REQ-023 CONN exits:
- in_stb_i=0 -> IDLE; ctrl_stb_o drops the same cycle, which releases the connection.
- deny bit while in CONN -> FAIL, and out_stb_o is forced 0 next cycle.
REQ-024 FAIL SHALL last one cycle with in_nack_o=1, ctrl_stb_o=0; then -> DRAIN.
REQ-025 DRAIN SHALL hold all request outputs 0 until in_stb_i=0, then -> IDLE.
REQ-026 If grant and deny are both set in REQ, grant SHALL win.
REQ-027 The retry counter SHALL be ceil(log2(MAX_RETRY+1)) bits and SHALL never wrap.
REQ-028 in_ack_o SHALL be 0 outside CONN.

Reset
REQ-029 On reset assertion, regardless of state, the block SHALL immediately go to IDLE.
REQ-030 While in reset:
- all outputs 0; out_data_o=0; retry and backoff counters 0.
- a request in progress is abandoned without an in_nack_o pulse.

Verification
REQ-031 V1: header 0x0002, grant[PORT_ID]=1 in REQ -> ctrl_dest_o=0100 for 1 cycle in REQ, CONN next cycle, out_data_o=0x0002 one cycle later.
REQ-032 V2: deny in REQ -> ctrl_stb_o=0 for 3 cycles (BACKOFF), then a second ctrl_src_o pulse; grant on that retry -> CONN.
REQ-033 V3: deny on all 8 REQs -> in_nack_o one-cycle pulse after the 8th; DRAIN until in_stb_i=0, then IDLE.
REQ-034 V4: CONN, 5 flits, in_stb_i drops -> out_stb_o high for exactly 5 cycles; ctrl_stb_o=0 in the same cycle in_stb_i=0.
REQ-035 V5: deny bit in CONN -> FAIL with in_nack_o=1, out_stb_o=0 next cycle.
REQ-036 V6: reset asserted mid-CONN, asynchronously -> all outputs 0 before the next edge; IDLE after release.
